poly_synth_core: RTL and testbench
==================================

# poly_synth_core

Parametrised polyphonic tone generator for the synthesizer datapath. It replaces the single-voice keypad → divider → oscillator → waveshaper → pwm chain with one block. It allocates up to VOICES simultaneously pressed keys to phase-accumulator voices, shapes each voice in a selectable waveform mode, mixes the voices into one sample, and drives a PWM audio pin. It sits between the keypad encoder and the board audio output.

## Interface
- VOICES, 4: number of voices; power of two, 1..8
- NKEYS, 13: number of note keys; key 0 = C4 through key 12 = C5
- ACC_W, 24: phase accumulator width
- SAMPLE_W, 8: sample and PWM resolution
- clk  in  1  system clock, 12 MHz
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable; low freezes the generator
- keys  in  NKEYS  debounced key levels; 1 = pressed
- mode  in  2  waveform: 0 square, 1 saw, 2 triangle, 3 sine (see Configuration)
- octave  in  2  octave shift up, 0..3
- sample_o  out  SAMPLE_W  mixed sample (registered)
- active_voices  out  $clog2(VOICES+1)  count of allocated voices
- pwm_o  out  1  PWM audio output

## Operation
- Allocation (combinational, every cycle): voice i takes the i-th lowest set bit of keys. Keys beyond the VOICES-th set bit are ignored. Voices with no key are inactive.
- Per voice, the registers are key_q, active_q and phase[ACC_W-1:0].
- When a voice's allocated key differs from key_q, or the voice changes inactive→active: phase is cleared to 0 and key_q is loaded.
- Otherwise, while the voice is active and en=1: phase += NOTE_INC[key_q] << octave, mod 2^ACC_W (wraps silently).
- An inactive voice holds phase=0.
- Waveform, using p = phase[ACC_W-1 -: SAMPLE_W]:
  - square: all-ones if p MSB=0, else 0.
  - saw: p.
  - triangle: {p[SAMPLE_W-2:0],1'b0} when p MSB=0, else its bitwise inverse.
  - sine: SINE_LUT[p].
  - An inactive voice contributes 0.
- Mixer: unsigned sum of all voice samples in SAMPLE_W+$clog2(VOICES) bits, then right-shifted by $clog2(VOICES). No saturation is needed.
- active_voices is the popcount of active_q, registered.
- PWM:
  - pwm_cnt is a free-running SAMPLE_W counter.
  - duty is loaded from sample_o when pwm_cnt wraps to 0.
  - pwm_o = (pwm_cnt < duty), registered.
  - duty 0 gives constant low; all-ones gives high for 2^SAMPLE_W−1 of 2^SAMPLE_W cycles.
- en=0:
  - phases hold, sample_o holds.
  - pwm_cnt is held at 0 and pwm_o is forced 0.
  - Allocation registers still update.

## Timing
- Reset: all phase, key_q, active_q, sample_o, active_voices, pwm_cnt, duty and pwm_o are 0.
- Pipeline: phase (edge n) → voice sample register (edge n+1) → sample_o (edge n+2). sample_o reflects phase with 2-cycle latency.
- A key change sampled at edge n clears the phase at edge n. active_voices updates at edge n, and sample_o shows the new voice at edge n+2.
- A new duty takes effect at the next pwm_cnt wrap, 1..2^SAMPLE_W cycles after sample_o changes.
- Simultaneous key release and press on the same voice index counts as a key change: the phase restarts.
- Changing octave or mode mid-note takes effect the next cycle, with no phase reset.
- Reset asserted mid-operation clears everything asynchronously. The first increment occurs at the first edge after rst deasserts.

## Configuration
- SYNTH_SINE_EN defined:
  - A 2^SAMPLE_W-entry quarter-wave-derived SINE_LUT is compiled in.
  - mode=3 selects sine.
- Undefined:
  - No LUT is built.
  - mode=3 behaves as square.

## Structure
- Package synth_pkg holds:
  - the wave_mode_t enum (SQUARE, SAW, TRI, SINE)
  - the NOTE_INC[13] constant table, computed as round(f·2^24/12e6) with C4=366 … C5=732
  - the SINE_LUT function, guarded by SYNTH_SINE_EN
- One sub-module, synth_voice, holds a single voice's phase accumulator and waveshaper. The top instantiates it VOICES times via generate, alongside the allocator, mixer and PWM.

## Test plan
- Reset check: assert rst with keys nonzero. All outputs must read 0. On release, phase is 0 at the first edge and 366 at the second, for key 0 with octave 0.
- Single-voice saw: keys=13'h001, mode=1, octave=2. Phase steps by 1464 per cycle. sample_o = (phase>>16)>>2 (VOICES=4) two cycles later. active_voices=1.
- Voice overflow: keys=13'h01F (5 keys) gives active_voices=4, and key 4 contributes nothing. Releasing key 0 reallocates voices 0–3 to keys 1–4, and all four phases restart at 0.
- PWM duty: hold sample_o=128. Across one 256-cycle PWM period, pwm_o is high exactly 128 cycles. sample_o=0 gives pwm_o constant 0.
- en low mid-note: phase and sample_o frozen, pwm_o=0. After en returns high, phase resumes from its held value.
- Sine mode: with SYNTH_SINE_EN, mode=3 and p=64 gives sample 255 at the peak. Without the macro, the same stimulus gives square output (255 for p<128, 0 otherwise).

Source files
------------

// File: rtl/synth_pkg.sv
// synth_pkg: waveform mode type, note phase-increment table and optional sine LUT.
// The LUT is only compiled when SYNTH_SINE_EN is defined.
package synth_pkg;

   typedef enum logic [1:0] {
      SQUARE = 2'd0,
      SAW    = 2'd1,
      TRI    = 2'd2,
      SINE   = 2'd3
   } wave_mode_t;

   localparam int unsigned NUM_NOTES = 13;

   // round(f * 2^24 / 12 MHz), C4 .. C5
   localparam logic [9:0] NOTE_INC [NUM_NOTES] = '{
      10'd366, 10'd388, 10'd411, 10'd435, 10'd461, 10'd488, 10'd517,
      10'd548, 10'd581, 10'd615, 10'd652, 10'd690, 10'd732
   };

`ifdef SYNTH_SINE_EN
   // round(127 * sin(2*pi*i/256)) for i = 0..64
   localparam logic [6:0] SINE_Q [65] = '{
      7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
      7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
      7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
      7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
      7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
      7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
      7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
      7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
      7'd127
   };

   function automatic logic [7:0] SINE_LUT(input logic [7:0] p);
      logic [6:0] idx;
      logic [6:0] q;
      // mirror the second quarter of each half-wave back onto the table
      idx = p[6] ? 7'(8'd128 - {1'b0, p[6:0]}) : p[6:0];
      q   = SINE_Q[idx];
      return p[7] ? (8'd127 - {1'b0, q}) : (8'd128 + {1'b0, q});
   endfunction
`endif

endpackage

// File: rtl/synth_voice.sv
// synth_voice: one voice's key tracking, phase accumulator and waveshaper.
// mode SINE uses the package LUT only when SYNTH_SINE_EN is defined, else square.
module synth_voice
   import synth_pkg::*;
#(
   parameter int unsigned ACC_W    = 24,
   parameter int unsigned SAMPLE_W = 8,
   parameter int unsigned KEY_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                key_valid,
   input  logic [KEY_W-1:0]    key,
   input  logic [1:0]          octave,
   input  wave_mode_t          mode,
   output logic [SAMPLE_W-1:0] sample
);

   logic [KEY_W-1:0]    key_q;
   logic                active_q;
   logic [ACC_W-1:0]    phase;
   logic [ACC_W-1:0]    step;
   logic [SAMPLE_W-1:0] p;
   logic [SAMPLE_W-1:0] tri_up;
   logic [SAMPLE_W-1:0] shaped;

   assign step   = ACC_W'(NOTE_INC[key_q]) << octave;
   assign p      = phase[ACC_W-1 -: SAMPLE_W];
   assign tri_up = {p[SAMPLE_W-2:0], 1'b0};

   always_comb begin
      shaped = '0;
      case (mode)
         SAW:     shaped = p;
         TRI:     shaped = p[SAMPLE_W-1] ? ~tri_up : tri_up;
`ifdef SYNTH_SINE_EN
         SINE:    shaped = SAMPLE_W'({SINE_LUT(phase[ACC_W-1 -: 8]), {SAMPLE_W{1'b0}}} >> 8);
`endif
         default: shaped = p[SAMPLE_W-1] ? '0 : '1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_q    <= '0;
         active_q <= 1'b0;
         phase    <= '0;
         sample   <= '0;
      end else begin
         // allocation tracking runs regardless of en; only accumulation is gated
         if (!key_valid) begin
            active_q <= 1'b0;
            phase    <= '0;
         end else if (!active_q || key != key_q) begin
            active_q <= 1'b1;
            key_q    <= key;
            phase    <= '0;
         end else if (en) begin
            phase <= phase + step;
         end
         if (en) begin
            sample <= active_q ? shaped : '0;
         end
      end
   end

endmodule

// File: rtl/poly_synth_core.sv
// poly_synth_core: key allocator, VOICES x synth_voice, mixer and PWM output stage.
// Define SYNTH_SINE_EN to enable the sine waveform for mode 3.
module poly_synth_core
   import synth_pkg::*;
#(
   parameter int unsigned VOICES   = 4,
   parameter int unsigned NKEYS    = 13,
   parameter int unsigned ACC_W    = 24,
   parameter int unsigned SAMPLE_W = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic [NKEYS-1:0]             keys,
   input  logic [1:0]                   mode,
   input  logic [1:0]                   octave,
   output logic [SAMPLE_W-1:0]          sample_o,
   output logic [$clog2(VOICES+1)-1:0]  active_voices,
   output logic                         pwm_o
);

   localparam int unsigned KEY_W  = $clog2(NKEYS);
   localparam int unsigned MIX_SH = $clog2(VOICES);
   localparam int unsigned MIX_W  = SAMPLE_W + MIX_SH;
   localparam int unsigned AV_W   = $clog2(VOICES+1);

   logic [KEY_W-1:0]    alloc_key [VOICES];
   logic [VOICES-1:0]   alloc_valid;
   logic [AV_W-1:0]     alloc_count;
   logic [SAMPLE_W-1:0] voice_sample [VOICES];
   logic [MIX_W-1:0]    mix_sum;
   logic [SAMPLE_W-1:0] pwm_cnt;
   logic [SAMPLE_W-1:0] duty;

   // voice v takes the v-th lowest pressed key; rank = pressed keys below k
   always_comb begin : alloc_scan
      int unsigned rank;
      rank        = 0;
      alloc_valid = '0;
      for (int unsigned v = 0; v < VOICES; v++) alloc_key[v] = '0;
      for (int unsigned k = 0; k < NKEYS; k++) begin
         if (keys[k]) begin
            for (int unsigned v = 0; v < VOICES; v++) begin
               if (rank == v) begin
                  alloc_key[v]   = KEY_W'(k);
                  alloc_valid[v] = 1'b1;
               end
            end
            rank++;
         end
      end
   end

   always_comb begin
      alloc_count = '0;
      for (int unsigned v = 0; v < VOICES; v++) alloc_count = alloc_count + AV_W'(alloc_valid[v]);
   end

   for (genvar v = 0; v < VOICES; v++) begin : g_voice
      synth_voice #(
         .ACC_W    (ACC_W),
         .SAMPLE_W (SAMPLE_W),
         .KEY_W    (KEY_W)
      ) u_voice (
         .clk       (clk),
         .rst       (rst),
         .en        (en),
         .key_valid (alloc_valid[v]),
         .key       (alloc_key[v]),
         .octave    (octave),
         .mode      (wave_mode_t'(mode)),
         .sample    (voice_sample[v])
      );
   end

   always_comb begin
      mix_sum = '0;
      for (int unsigned v = 0; v < VOICES; v++) mix_sum = mix_sum + MIX_W'(voice_sample[v]);
   end

   // alloc_count equals the popcount of every voice's active flag after this edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_o      <= '0;
         active_voices <= '0;
      end else begin
         active_voices <= alloc_count;
         if (en) sample_o <= SAMPLE_W'(mix_sum >> MIX_SH);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt <= '0;
         duty    <= '0;
         pwm_o   <= 1'b0;
      end else if (!en) begin
         pwm_cnt <= '0;
         pwm_o   <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         if (pwm_cnt == '1) duty <= sample_o;
         pwm_o <= (pwm_cnt < duty);
      end
   end

endmodule

// File: tb/tb_poly_synth_core.sv
// Self-checking bench for poly_synth_core: vector table, hand sequences and a
// randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_poly_synth_core;

   localparam int unsigned VOICES   = 4;
   localparam int unsigned NKEYS    = 13;
   localparam int unsigned ACC_W    = 24;
   localparam int unsigned SAMPLE_W = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [12:0] keys;
   logic [1:0]  mode;
   logic [1:0]  octave;
   logic [7:0]  sample_o;
   logic [2:0]  active_voices;
   logic        pwm_o;

   always #5 clk = ~clk;

   poly_synth_core #(
      .VOICES   (VOICES),
      .NKEYS    (NKEYS),
      .ACC_W    (ACC_W),
      .SAMPLE_W (SAMPLE_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .keys          (keys),
      .mode          (mode),
      .octave        (octave),
      .sample_o      (sample_o),
      .active_voices (active_voices),
      .pwm_o         (pwm_o)
   );

   int tests = 0;
   int fails = 0;

   int unsigned note_inc [13] = '{366, 388, 411, 435, 461, 488, 517, 548, 581, 615, 652, 690, 732};

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int unsigned m_phase [VOICES];
   int unsigned m_key   [VOICES];
   int unsigned m_vs    [VOICES];
   bit          m_act   [VOICES];
   int unsigned m_sample;
   int unsigned m_av;

   function automatic int unsigned wave(input int unsigned ph, input int unsigned m);
      int unsigned p;
      int unsigned half;
      int unsigned full;
      p    = ph >> (ACC_W - SAMPLE_W);
      half = 1 << (SAMPLE_W - 1);
      full = (1 << SAMPLE_W) - 1;
      case (m)
         1:       return p;
         2:       return (p < half) ? 2 * p : full - 2 * (p - half);
         default: return (p < half) ? full : 0;
      endcase
   endfunction

   task automatic model_reset();
      for (int v = 0; v < VOICES; v++) begin
         m_phase[v] = 0; m_key[v] = 0; m_vs[v] = 0; m_act[v] = 0;
      end
      m_sample = 0;
      m_av     = 0;
   endtask

   task automatic model_step(input logic [12:0] k, input int unsigned md, input int unsigned oct, input bit e);
      int unsigned pressed[$];
      int unsigned sum;
      if (e) begin
         sum = 0;
         for (int v = 0; v < VOICES; v++) sum += m_vs[v];
         m_sample = sum / VOICES;
         for (int v = 0; v < VOICES; v++) m_vs[v] = m_act[v] ? wave(m_phase[v], md) : 0;
      end
      for (int i = 0; i < NKEYS; i++)
         if (k[i] && pressed.size() < VOICES) pressed.push_back(i);
      m_av = pressed.size();
      for (int v = 0; v < VOICES; v++) begin
         if (v >= pressed.size()) begin
            m_act[v] = 0; m_phase[v] = 0;
         end else if (!m_act[v] || m_key[v] != pressed[v]) begin
            m_act[v] = 1; m_key[v] = pressed[v]; m_phase[v] = 0;
         end else if (e) begin
            m_phase[v] = (m_phase[v] + (note_inc[m_key[v]] << oct)) % (1 << ACC_W);
         end
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [12:0] keys;
      logic [1:0]  mode;
      logic [1:0]  oct;
      int unsigned cycles;
      int unsigned exp_av;
      int unsigned exp_sample;
   } vec_t;

   vec_t vecs [13];

   task automatic restart(input logic [12:0] k, input logic [1:0] md, input logic [1:0] oct);
      rst = 1'b1; en = 1'b1; keys = k; mode = md; octave = oct;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   int unsigned held_sample;
   int unsigned held_phase;
   int unsigned highs;

   initial begin
      rst = 1'b1; en = 1'b0; keys = '0; mode = '0; octave = '0;

      vecs[0]  = '{13'h0001, 2'd1, 2'd2, 1003, 1, 5};
      vecs[1]  = '{13'h0001, 2'd0, 2'd0, 10,   1, 63};
      vecs[2]  = '{13'h000F, 2'd0, 2'd0, 10,   4, 255};
      vecs[3]  = '{13'h001F, 2'd0, 2'd0, 10,   4, 255};
      vecs[4]  = '{13'h0000, 2'd0, 2'd0, 10,   0, 0};
      vecs[5]  = '{13'h1000, 2'd1, 2'd3, 2003, 1, 44};
      vecs[6]  = '{13'h0001, 2'd2, 2'd3, 5003, 1, 16};
      vecs[7]  = '{13'h0001, 2'd2, 2'd3, 1003, 1, 22};
      vecs[8]  = '{13'h0001, 2'd1, 2'd3, 6003, 1, 3};
`ifdef SYNTH_SINE_EN
      vecs[9]  = '{13'h0001, 2'd3, 2'd0, 10,   1, 32};
`else
      vecs[9]  = '{13'h0001, 2'd3, 2'd0, 10,   1, 63};
`endif
      vecs[10] = '{13'h0001, 2'd3, 2'd3, 1436, 1, 63};
      vecs[11] = '{13'h0001, 2'd3, 2'd3, 4301, 1, 0};
      vecs[12] = '{13'h0020, 2'd1, 2'd1, 3003, 1, 11};

      // reset state with keys held
      keys = 13'h0001; mode = 2'd1; octave = 2'd0; en = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_sample", sample_o, 0);
      check("rst_active", active_voices, 0);
      check("rst_pwm", pwm_o, 0);
      check("rst_phase", dut.g_voice[0].u_voice.phase, 0);
      rst = 1'b0;
      @(negedge clk);
      check("first_edge_phase", dut.g_voice[0].u_voice.phase, 0);
      check("first_edge_active", active_voices, 1);
      @(negedge clk);
      check("second_edge_phase", dut.g_voice[0].u_voice.phase, 366);

      // asynchronous reset mid-operation
      repeat (20) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_phase", dut.g_voice[0].u_voice.phase, 0);
      check("async_rst_active", active_voices, 0);
      @(negedge clk);

      for (int i = 0; i < 13; i++) begin
         restart(vecs[i].keys, vecs[i].mode, vecs[i].oct);
         repeat (vecs[i].cycles) @(posedge clk);
         @(negedge clk);
         check($sformatf("vec%0d_sample", i), sample_o, vecs[i].exp_sample);
         check($sformatf("vec%0d_active", i), active_voices, vecs[i].exp_av);
      end

      // voice overflow and reallocation
      restart(13'h001F, 2'd1, 2'd3);
      repeat (500) @(negedge clk);
      check("ovf_active", active_voices, 4);
      keys = 13'h001E;
      @(negedge clk);
      check("realloc_active", active_voices, 4);
      check("realloc_ph0", dut.g_voice[0].u_voice.phase, 0);
      check("realloc_ph1", dut.g_voice[1].u_voice.phase, 0);
      check("realloc_ph2", dut.g_voice[2].u_voice.phase, 0);
      check("realloc_ph3", dut.g_voice[3].u_voice.phase, 0);
      @(negedge clk);
      check("realloc_ph0_step", dut.g_voice[0].u_voice.phase, 388 * 8);
      @(negedge clk);
      check("realloc_sample", sample_o, 0);

      // PWM duty 127, 255, 0
      restart(13'h0003, 2'd0, 2'd0);
      repeat (600) @(negedge clk);
      check("pwm_src_127", sample_o, 127);
      highs = 0;
      repeat (512) begin @(negedge clk); highs += pwm_o; end
      check("pwm_duty127", highs, 254);
      keys = 13'h000F;
      repeat (600) @(negedge clk);
      highs = 0;
      repeat (256) begin @(negedge clk); highs += pwm_o; end
      check("pwm_duty255", highs, 255);
      keys = 13'h0000;
      repeat (600) @(negedge clk);
      highs = 0;
      repeat (256) begin @(negedge clk); highs += pwm_o; end
      check("pwm_duty0", highs, 0);

      // en low mid-note
      restart(13'h0001, 2'd1, 2'd3);
      repeat (1000) @(negedge clk);
      held_sample = sample_o;
      held_phase  = dut.g_voice[0].u_voice.phase;
      en = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check("en0_sample", sample_o, held_sample);
         check("en0_phase", dut.g_voice[0].u_voice.phase, held_phase);
         check("en0_pwm", pwm_o, 0);
      end
      en = 1'b1;
      repeat (5) @(negedge clk);
      check("en_resume_phase", dut.g_voice[0].u_voice.phase, held_phase + 5 * 2928);

      // randomized run against the model
      restart(13'h0005, 2'd1, 2'd3);
      model_reset();
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(299) == 0) keys = 13'($urandom & $urandom);
         if ($urandom_range(99) == 0)  mode = 2'($urandom_range(2));
         if ($urandom_range(199) == 0) octave = 2'($urandom_range(3));
         en = ($urandom_range(19) != 0);
         @(posedge clk);
         model_step(keys, mode, octave, en);
         @(negedge clk);
         check("rand_sample", sample_o, m_sample);
         check("rand_active", active_voices, m_av);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
